// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM encoding, bit-period and parity helpers
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_fsm_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int uart_div(input int clk_freq, input int datarate);
    return clk_freq / datarate;
  endfunction

  function automatic logic uart_parity(input logic [7:0] data, input int databits,
                                       input int paritybit);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < databits) p = p ^ data[i];
    end
    return (paritybit == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous transmit FIFO, registered storage, no bypass
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr;
  logic             w_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wr    = push_i & ~full_o;
  assign w_rd    = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: byte FIFO in, start/data/parity/stop frames out
module uart_tx
  import uart_pkg::*;
#(
  parameter int    CLK_FREQ   = 100_000_000,
  parameter int    DATARATE   = 9600,
  parameter int    STOPBITS   = 1,
  parameter int    DATABITS   = 8,
  parameter string PARITYBIT  = "NONE",
  parameter int    FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int DIV      = uart_div(CLK_FREQ, DATARATE);
  localparam int PAR_MODE = (PARITYBIT == "EVEN") ? PAR_EVEN :
                            (PARITYBIT == "ODD")  ? PAR_ODD  : PAR_NONE;
  localparam int STOP_CYC = STOPBITS * DIV;
  localparam int CW       = $clog2(STOP_CYC);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx: CLK_FREQ/DATARATE must be at least 2");
  end
  if (DATABITS < 5 || DATABITS > 8) begin : g_bad_databits
    $error("uart_tx: DATABITS must be 5..8");
  end
  if (STOPBITS < 1 || STOPBITS > 2) begin : g_bad_stopbits
    $error("uart_tx: STOPBITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of 2, at least 2");
  end

  uart_fsm_t     r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_sr;
  logic          r_par;
  logic          r_tx;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_fifo_data;
  logic          w_bit_end;
  logic          w_stop_end;

  assign w_push     = valid_i & ~w_full;
  assign w_bit_end  = (r_clk_cnt == CW'(DIV - 1));
  assign w_stop_end = (r_clk_cnt == CW'(STOP_CYC - 1));
  assign w_pop      = ((r_state == IDLE) || (r_state == STOP && w_stop_end)) && !w_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (data_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // r_tx is loaded with the level of the bit being entered, so each level
  // appears on the pin the cycle after the transition that selects it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_sr      <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_sr      <= w_fifo_data;
            r_par     <= uart_parity(w_fifo_data, DATABITS, PAR_MODE);
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_state   <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_tx      <= r_sr[0];
            r_state   <= DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 3'(DATABITS - 1)) begin
              if (PAR_MODE != PAR_NONE) begin
                r_tx    <= r_par;
                r_state <= PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_sr      <= r_sr >> 1;
              r_tx      <= r_sr[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_tx      <= 1'b1;
            r_state   <= STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_stop_end) begin
            r_clk_cnt <= '0;
            if (w_pop) begin
              r_sr      <= w_fifo_data;
              r_par     <= uart_parity(w_fifo_data, DATABITS, PAR_MODE);
              r_bit_cnt <= '0;
              r_tx      <= 1'b0;
              r_state   <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o    = r_tx;
  assign ready_o = ~w_full;
  assign busy_o  = ~w_empty | (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx across 8N1/8E1/8O1/8N2/5N1 at DIV=10
module tb_uart_tx;

  localparam int DIV   = 10;
  localparam int NI    = 5;
  localparam int DEPTH = 4;
  localparam int DB [NI] = '{8, 8, 8, 8, 5};
  localparam int PM [NI] = '{0, 1, 2, 0, 0};
  localparam int SB [NI] = '{1, 1, 1, 2, 1};

  logic          clk = 1'b0;
  logic [NI-1:0] rst;
  logic [NI-1:0] valid;
  logic [7:0]    data [NI];
  logic [NI-1:0] tx;
  logic [NI-1:0] busy;
  logic [NI-1:0] ready;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(100_000_000), .DATARATE(10_000_000), .STOPBITS(1), .DATABITS(8),
            .PARITYBIT("NONE"), .FIFO_DEPTH(DEPTH)) u_8n1 (
    .clk_i(clk), .rst_i(rst[0]), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]));
  uart_tx #(.CLK_FREQ(100_000_000), .DATARATE(10_000_000), .STOPBITS(1), .DATABITS(8),
            .PARITYBIT("EVEN"), .FIFO_DEPTH(DEPTH)) u_8e1 (
    .clk_i(clk), .rst_i(rst[1]), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]));
  uart_tx #(.CLK_FREQ(100_000_000), .DATARATE(10_000_000), .STOPBITS(1), .DATABITS(8),
            .PARITYBIT("ODD"), .FIFO_DEPTH(DEPTH)) u_8o1 (
    .clk_i(clk), .rst_i(rst[2]), .data_i(data[2]), .valid_i(valid[2]),
    .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]));
  uart_tx #(.CLK_FREQ(100_000_000), .DATARATE(10_000_000), .STOPBITS(2), .DATABITS(8),
            .PARITYBIT("NONE"), .FIFO_DEPTH(DEPTH)) u_8n2 (
    .clk_i(clk), .rst_i(rst[3]), .data_i(data[3]), .valid_i(valid[3]),
    .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]));
  uart_tx #(.CLK_FREQ(100_000_000), .DATARATE(10_000_000), .STOPBITS(1), .DATABITS(5),
            .PARITYBIT("NONE"), .FIFO_DEPTH(DEPTH)) u_5n1 (
    .clk_i(clk), .rst_i(rst[4]), .data_i(data[4]), .valid_i(valid[4]),
    .ready_o(ready[4]), .tx_o(tx[4]), .busy_o(busy[4]));

  // Model: a byte queue plus the frame currently on the line, held as a list of bit levels.
  logic [7:0] mq [NI][$];
  bit         lv [NI][12];
  int         fr_len [NI];
  int         fr_cyc [NI];
  bit         active [NI];

  function automatic void load_frame(int k, logic [7:0] b);
    int n;
    int ones;
    n = 0;
    ones = 0;
    lv[k][n] = 1'b0; n++;
    for (int i = 0; i < DB[k]; i++) begin
      lv[k][n] = b[i]; n++;
      if (b[i]) ones++;
    end
    if (PM[k] != 0) begin
      lv[k][n] = (PM[k] == 1) ? (ones % 2 == 1) : (ones % 2 == 0); n++;
    end
    for (int i = 0; i < SB[k]; i++) begin
      lv[k][n] = 1'b1; n++;
    end
    fr_len[k] = n * DIV;
    fr_cyc[k] = 0;
    active[k] = 1'b1;
  endfunction

  always @(posedge clk) begin
    bit pop;
    bit push;
    int sz;
    for (int k = 0; k < NI; k++) begin
      if (rst[k]) begin
        mq[k].delete();
        active[k] = 1'b0;
        fr_cyc[k] = 0;
      end else begin
        sz  = mq[k].size();
        pop = 1'b0;
        if (active[k]) begin
          fr_cyc[k]++;
          if (fr_cyc[k] == fr_len[k]) begin
            active[k] = 1'b0;
            pop = (sz > 0);
          end
        end else begin
          pop = (sz > 0);
        end
        push = valid[k] && (sz < DEPTH);
        if (pop) load_frame(k, mq[k].pop_front());
        if (push) mq[k].push_back(data[k]);
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    bit e_tx;
    bit e_busy;
    bit e_ready;
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        e_tx    = active[k] ? lv[k][fr_cyc[k] / DIV] : 1'b1;
        e_busy  = active[k] || (mq[k].size() > 0);
        e_ready = (mq[k].size() < DEPTH);
        chk1($sformatf("model tx%0d", k), tx[k], e_tx);
        chk1($sformatf("model busy%0d", k), busy[k], e_busy);
        chk1($sformatf("model ready%0d", k), ready[k], e_ready);
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int k, input int maxc, input string nm);
    int c;
    c = 0;
    while (busy[k] && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk1(nm, busy[k], 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e55 [10];
    int acc;
    int highs;
    int lows;
    e55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    rst   = '1;
    valid = '0;
    for (int k = 0; k < NI; k++) data[k] = 8'h00;
    wait_neg(3);
    rst    = '0;
    chk_en = 1'b1;
    chk1("reset tx", tx[0], 1'b1);
    chk1("reset ready", ready[0], 1'b1);
    chk1("reset busy", busy[0], 1'b0);

    // 8N1, 0x55: mid-bit samples from the cycle after the pop
    @(negedge clk); data[0] = 8'h55; valid[0] = 1'b1;
    @(negedge clk); valid[0] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      wait_neg((i == 0) ? 5 : 10);
      chk1($sformatf("8N1 0x55 bit%0d", i), tx[0], e55[i][0]);
    end
    wait_neg(4);
    chk1("8N1 busy at 99", busy[0], 1'b1);
    wait_neg(1);
    chk1("8N1 busy at 100", busy[0], 1'b0);
    chk1("8N1 idle high", tx[0], 1'b1);

    // 8E1 and 8O1, 0x07
    @(negedge clk); data[1] = 8'h07; data[2] = 8'h07; valid[1] = 1'b1; valid[2] = 1'b1;
    @(negedge clk); valid[1] = 1'b0; valid[2] = 1'b0;
    @(negedge clk);
    wait_neg(85);
    chk1("8E1 data bit7", tx[1], 1'b0);
    wait_neg(10);
    chk1("8E1 parity", tx[1], 1'b1);
    chk1("8O1 parity", tx[2], 1'b0);
    wait_neg(14);
    chk1("8E1 busy at 109", busy[1], 1'b1);
    chk1("8O1 busy at 109", busy[2], 1'b1);
    wait_neg(1);
    chk1("8E1 busy at 110", busy[1], 1'b0);
    chk1("8O1 busy at 110", busy[2], 1'b0);

    // 8N2, 0xA5 then 0x3C back to back
    @(negedge clk); data[3] = 8'hA5; valid[3] = 1'b1;
    @(negedge clk); data[3] = 8'h3C;
    @(negedge clk); valid[3] = 1'b0;
    wait_neg(90);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx[3]) highs++;
      @(negedge clk);
    end
    chkn("8N2 stop high cycles", highs, 20);
    chk1("8N2 second start", tx[3], 1'b0);
    wait_neg(15);
    chk1("8N2 0x3C bit0", tx[3], 1'b0);
    wait_neg(20);
    chk1("8N2 0x3C bit2", tx[3], 1'b1);
    wait_neg(10);
    chk1("8N2 0x3C bit3", tx[3], 1'b1);
    wait_idle(3, 200, "8N2 idle timeout");

    // 5N1, 0xFF then 0xE0 (upper bits ignored)
    @(negedge clk); data[4] = 8'hFF; valid[4] = 1'b1;
    @(negedge clk); valid[4] = 1'b0;
    @(negedge clk);
    wait_neg(5);
    chk1("5N1 start", tx[4], 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_neg(10);
      chk1($sformatf("5N1 data bit%0d", i), tx[4], 1'b1);
    end
    wait_neg(14);
    chk1("5N1 busy at 69", busy[4], 1'b1);
    wait_neg(1);
    chk1("5N1 busy at 70", busy[4], 1'b0);
    @(negedge clk); data[4] = 8'hE0; valid[4] = 1'b1;
    @(negedge clk); valid[4] = 1'b0;
    @(negedge clk);
    wait_neg(15);
    chk1("5N1 0xE0 bit0", tx[4], 1'b0);
    wait_idle(4, 100, "5N1 idle timeout");

    // FIFO fill: valid held for 6 cycles
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data[0]  = 8'h11 + 8'(i);
      valid[0] = 1'b1;
      if (ready[0]) acc++;
    end
    @(negedge clk); valid[0] = 1'b0;
    chkn("fifo accepted", acc, 5);
    chk1("fifo ready low", ready[0], 1'b0);
    wait_idle(0, 700, "fifo drain timeout");

    // Reset during bit 3 of 0xF0 with three bytes queued
    @(negedge clk); data[0] = 8'hF0; valid[0] = 1'b1;
    @(negedge clk); data[0] = 8'h01;
    @(negedge clk); data[0] = 8'h02;
    @(negedge clk); data[0] = 8'h03;
    @(negedge clk); valid[0] = 1'b0;
    wait_neg(42);
    chk1("0xF0 bit3", tx[0], 1'b0);
    chk1("queued busy", busy[0], 1'b1);
    rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    chk1("post-reset tx", tx[0], 1'b1);
    chk1("post-reset busy", busy[0], 1'b0);
    chk1("post-reset ready", ready[0], 1'b1);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (!tx[0]) lows++;
    end
    chkn("no frames after reset", lows, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
